// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Each one-cycle rx_valid pulse is captured into a circular buffer.
// The host reads through a first-word-fall-through valid/ready interface.
// The block also drives an almost-full level for RTS and a sticky overflow flag.
// Optional feature: define UART_RX_FIFO_BREAK_EN to store the break bit with each entry.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16,
    parameter int AF_LEVEL     = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [PAYLOAD_BITS-1:0]   rx_data,
    input  logic                      rx_break,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [PAYLOAD_BITS-1:0]   rd_data,
    output logic                      rd_break,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      rx_almost_full,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_RX_FIFO_BREAK_EN
    localparam int EW = PAYLOAD_BITS + 1;
`else
    localparam int EW = PAYLOAD_BITS;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] head_word;
    logic          push;
    logic          pop;
    logic          drop;

    // Status flags come only from the occupancy counter, never from pointer equality
    assign empty          = (count == '0);
    assign full           = (count == CW'(DEPTH));
    assign rx_almost_full = (count >= CW'(AF_LEVEL));
    assign rd_valid       = !empty;

`ifdef UART_RX_FIFO_BREAK_EN
    assign wr_word = {rx_break, rx_data};
`else
    logic unused_break;
    assign unused_break = rx_break;
    assign wr_word      = rx_data;
`endif

    // Accept a word when there is room, or when a pop in this cycle frees a slot
    always_comb begin
        pop  = rd_valid && rd_ready;
        push = rx_valid && (!full || pop);
        drop = rx_valid && full && !pop;
    end

    // Storage array; contents survive reset because the counter marks them invalid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Head entry is visible combinationally and reads as zero while empty
    always_comb begin
        head_word = mem[rd_ptr];
        rd_data   = '0;
        rd_break  = 1'b0;
        if (!empty) begin
            rd_data = head_word[PAYLOAD_BITS-1:0];
`ifdef UART_RX_FIFO_BREAK_EN
            rd_break = head_word[PAYLOAD_BITS];
`endif
        end
    end

    // Pointers wrap naturally; occupancy moves only when exactly one of push/pop happens
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DEPTH=16, AF_LEVEL=12, 8-bit payload).
// Expected words are queued when a push is accepted, and a monitor pops and compares them on reads.
// Directed checks cover reset, almost-full, full, overflow, break and async reset.
module tb_uart_rx_fifo;

    localparam int PAYLOAD_BITS = 8;
    localparam int DEPTH        = 16;
    localparam int AF_LEVEL     = 12;

`ifdef UART_RX_FIFO_BREAK_EN
    localparam logic BRK_STORED = 1'b1;
`else
    localparam logic BRK_STORED = 1'b0;
`endif

    logic                    clk;
    logic                    reset;
    logic                    rx_valid;
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_break;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [PAYLOAD_BITS-1:0] rd_data;
    logic                    rd_break;
    logic [4:0]              count;
    logic                    empty;
    logic                    full;
    logic                    rx_almost_full;
    logic                    overflow;
    logic                    overflow_clr;

    int checks = 0;
    int errors = 0;

    logic [8:0] model_q [$];
    int         model_count  = 0;
    logic       exp_overflow = 1'b0;
    logic [8:0] last_popped  = '0;

    uart_rx_fifo #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .DEPTH        (DEPTH),
        .AF_LEVEL     (AF_LEVEL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_break       (rx_break),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_break       (rd_break),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .rx_almost_full (rx_almost_full),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of receiver input starting just after a rising edge
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic brk);
        rx_valid = valid;
        rx_data  = data;
        rx_break = brk;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_break = 1'b0;
    endtask

    // Reference occupancy model, advanced at each clock edge from the driven inputs
    always @(posedge clk or posedge reset) begin
        bit m_pop;
        bit m_push;
        if (reset) begin
            model_q.delete();
            model_count  = 0;
            exp_overflow = 1'b0;
        end else begin
            m_pop  = rd_ready && (model_count > 0);
            m_push = rx_valid && ((model_count < DEPTH) || m_pop);
            if (m_push) begin
                model_q.push_back({rx_break & BRK_STORED, rx_data});
            end
            model_count = model_count + int'(m_push) - int'(m_pop);
            if (rx_valid && !m_push) begin
                exp_overflow = 1'b1;
            end else if (overflow_clr) begin
                exp_overflow = 1'b0;
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard whenever the host takes a word
    always @(negedge clk) begin
        logic [8:0] exp_word;
        checkOutput("mon_count", 32'(count), 32'(model_count));
        checkOutput("mon_rd_valid", 32'(rd_valid), 32'(model_count > 0));
        checkOutput("mon_full", 32'(full), 32'(model_count == DEPTH));
        checkOutput("mon_almost_full", 32'(rx_almost_full), 32'(model_count >= AF_LEVEL));
        checkOutput("mon_overflow", 32'(overflow), 32'(exp_overflow));
        if (model_count == 0) begin
            checkOutput("mon_empty_head", 32'({rd_break, rd_data}), 32'h0);
        end
        if (!reset && rd_valid && rd_ready) begin
            if (model_q.size() == 0) begin
                checkOutput("mon_underflow", 32'(rd_valid), 32'h0);
            end else begin
                exp_word    = model_q.pop_front();
                last_popped = {rd_break, rd_data};
                checkOutput("mon_head_word", 32'({rd_break, rd_data}), 32'(exp_word));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = '0;
        rx_break     = 1'b0;
        rd_ready     = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_empty", 32'(empty), 32'h1);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0);

        $display("[TB] basic ordering");
        applyStimulus(1'b1, 8'h41, 1'b0);
        checkOutput("first_word_latency", 32'(rd_data), 32'h41);
        applyStimulus(1'b1, 8'h42, 1'b0);
        applyStimulus(1'b1, 8'h43, 1'b0);
        checkOutput("count_three", 32'(count), 32'h3);
        rd_ready = 1'b1;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drained_empty", 32'(empty), 32'h1);
        checkOutput("drained_rd_data", 32'(rd_data), 32'h0);
        applyStimulus(1'b1, 8'h99, 1'b0);
        checkOutput("empty_ready_write_count", 32'(count), 32'h1);
        checkOutput("empty_ready_write_data", 32'(rd_data), 32'h99);
        applyStimulus(1'b0, 8'h00, 1'b0);
        rd_ready = 1'b0;
        checkOutput("empty_after_99", 32'(empty), 32'h1);

        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_almost_full", 32'(rx_almost_full), 32'((i + 1) >= AF_LEVEL));
        end
        checkOutput("fill_full", 32'(full), 32'h1);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("drop_overflow", 32'(overflow), 32'h1);
        checkOutput("drop_count", 32'(count), 32'h10);
        overflow_clr = 1'b1;
        applyStimulus(1'b1, 8'hAB, 1'b0);
        checkOutput("clr_vs_drop", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        overflow_clr = 1'b0;
        checkOutput("clr_alone", 32'(overflow), 32'h0);

        $display("[TB] full with simultaneous pop");
        rd_ready = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("full_pop_count", 32'(count), 32'h10);
        repeat (DEPTH) applyStimulus(1'b0, 8'h00, 1'b0);
        rd_ready = 1'b0;
        checkOutput("last_word_out", 32'(last_popped), 32'h055);
        checkOutput("full_drain_empty", 32'(empty), 32'h1);

        $display("[TB] break words");
        applyStimulus(1'b1, 8'h00, 1'b1);
        checkOutput("break_flag", 32'(rd_break), 32'(BRK_STORED));
        applyStimulus(1'b1, 8'h30, 1'b0);
        rd_ready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("normal_after_break_flag", 32'(rd_break), 32'h0);
        checkOutput("normal_after_break_data", 32'(rd_data), 32'h30);
        applyStimulus(1'b0, 8'h00, 1'b0);
        rd_ready = 1'b0;

        $display("[TB] asynchronous reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
        end
        checkOutput("pre_reset_count", 32'(count), 32'h5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_count", 32'(count), 32'h0);
        checkOutput("async_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("async_rd_data", 32'(rd_data), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 8'h7E, 1'b0);
        checkOutput("post_reset_data", 32'(rd_data), 32'h7E);
        checkOutput("post_reset_count", 32'(count), 32'h1);
        rd_ready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        rd_ready = 1'b0;
        checkOutput("post_reset_empty", 32'(empty), 32'h1);
        checkOutput("post_reset_last", 32'(last_popped), 32'h07E);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
